// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: pin synchronizer, clock de-glitch filter,
// 11-bit frame deserializer and watchdog. Optional macro: PS2_RX_PARITY_CHK_EN.
module ps2_rx_frame #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_US  = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       valid,
  output logic [7:0] scan_code,
  output logic       frame_err
);

  localparam int TIMEOUT_CYC = CLK_FREQ_HZ / 1_000_000 * TIMEOUT_US;
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int WW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t         state, state_next;
  logic [1:0]     clk_sync, data_sync;
  logic           filt_clk, filt_prev;
  logic [FW-1:0]  filt_cnt;
  logic [7:0]     sreg;
  logic [2:0]     bit_cnt;
  logic [WW-1:0]  wd_cnt;
  logic           fall_evt, bit_in, wd_hit, par_ok, accept, reject;
`ifdef PS2_RX_PARITY_CHK_EN
  logic           par_bit;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  // The filtered clock follows the pin only after FILTER_LEN steady cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      filt_clk  <= 1'b1;
      filt_prev <= 1'b1;
      filt_cnt  <= '0;
    end else begin
      filt_prev <= filt_clk;
      if (clk_sync[1] == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        filt_clk <= clk_sync[1];
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end
  end

  assign fall_evt = filt_prev & ~filt_clk;
  assign bit_in   = data_sync[1];
  // A fall event in the expiry cycle takes priority over the watchdog.
  assign wd_hit   = (state != IDLE) && !fall_evt && (wd_cnt == WW'(TIMEOUT_CYC - 1));

`ifdef PS2_RX_PARITY_CHK_EN
  assign par_ok = ^{sreg, par_bit};
`else
  assign par_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (fall_evt && !bit_in) state_next = DATA;
      DATA:   if (fall_evt && bit_cnt == 3'd7) state_next = PARITY;
      PARITY: if (fall_evt) state_next = STOP;
      STOP:   if (fall_evt) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (wd_hit) state_next = IDLE;
  end

  always_comb begin
    accept = (state == STOP) && fall_evt && bit_in && par_ok;
    reject = ((state == STOP) && fall_evt && !(bit_in && par_ok)) || wd_hit;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      scan_code <= 8'h00;
      sreg      <= 8'h00;
      bit_cnt   <= 3'd0;
      wd_cnt    <= '0;
`ifdef PS2_RX_PARITY_CHK_EN
      par_bit   <= 1'b0;
`endif
    end else begin
      valid     <= accept;
      frame_err <= reject;
      if (accept) scan_code <= sreg;
      if (fall_evt) begin
        case (state)
          IDLE: bit_cnt <= 3'd0;
          DATA: begin
            sreg    <= {bit_in, sreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          PARITY: begin
`ifdef PS2_RX_PARITY_CHK_EN
            par_bit <= bit_in;
`endif
          end
          default: ;
        endcase
      end
      if (state == IDLE || fall_evt || wd_hit) wd_cnt <= '0;
      else                                      wd_cnt <= wd_cnt + WW'(1);
    end
  end

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Self-checking bench for ps2_rx_frame: directed frame table, randomized frames
// against a frame-level reference model, watchdog, glitch and reset sequences.
module tb_ps2_rx_frame;

  localparam int CLK_FREQ_HZ = 1_000_000;
  localparam int FILTER_LEN  = 8;
  localparam int TIMEOUT_US  = 200;
  localparam int TIMEOUT_CYC = CLK_FREQ_HZ / 1_000_000 * TIMEOUT_US;
  localparam int BIT_HALF    = 30;
  localparam int LEAD        = 15;
  localparam int PULSE_LAT   = 2 + FILTER_LEN + 1;
`ifdef PS2_RX_PARITY_CHK_EN
  localparam bit PARITY_CHK = 1'b1;
`else
  localparam bit PARITY_CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       valid, frame_err;
  logic [7:0] scan_code;

  int tests = 0;
  int failed = 0;
  int cyc = 0;
  int lastFall = 0;
  int vCount = 0, eCount = 0, lastValidCyc = 0, lastErrCyc = 0;
  int overlapCount = 0, longCount = 0;
  logic prevV = 1'b0, prevE = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    int         expValid;
    int         expErr;
    logic [7:0] expCode;
    int         gap;
  } vec_t;

  vec_t vecs[6];

  ps2_rx_frame #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ),
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT_US (TIMEOUT_US)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .valid    (valid),
    .scan_code(scan_code),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: counts and timestamps pulses, flags overlaps and stretched pulses.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      vCount       <= vCount + 1;
      lastValidCyc <= cyc;
    end
    if (frame_err === 1'b1) begin
      eCount     <= eCount + 1;
      lastErrCyc <= cyc;
    end
    if (valid === 1'b1 && frame_err === 1'b1) overlapCount <= overlapCount + 1;
    if ((valid === 1'b1 && prevV) || (frame_err === 1'b1 && prevE)) longCount <= longCount + 1;
    prevV <= (valid === 1'b1);
    prevE <= (frame_err === 1'b1);
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input int v0, input int e0,
                             input int expV, input int expE, input logic [7:0] expCode);
    check({name, " valid count"}, vCount - v0, expV);
    check({name, " frame_err count"}, eCount - e0, expE);
    check({name, " scan_code"}, int'(scan_code), int'(expCode));
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic par, input logic stop,
                               input int nbits, input int glitchBit, input int resetBit);
    logic [10:0] bits;
    bits = {stop, par, data, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      if (i == glitchBit) begin
        waitCycles(4);
        ps2_clk = 1'b0;
        waitCycles(7);
        ps2_clk = 1'b1;
        waitCycles(LEAD - 11);
      end else begin
        waitCycles(LEAD);
      end
      ps2_clk  = 1'b0;
      lastFall = cyc;
      if (i == resetBit) begin
        waitCycles(3);
        rst_n    = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        waitCycles(5);
        return;
      end
      waitCycles(BIT_HALF);
      ps2_clk = 1'b1;
      waitCycles(LEAD);
    end
    ps2_data = 1'b1;
  endtask

  initial begin
    int v0, e0;
    logic [7:0] modelCode;
    logic [7:0] rData;
    logic       rPar, rStop;
    bit         rOk;

    vecs[0] = '{8'h1C, 1'b0, 1'b1, 1, 0, 8'h1C, 60};
    vecs[1] = '{8'hF0, 1'b1, 1'b1, 1, 0, 8'hF0, 0};
    vecs[2] = '{8'h1C, 1'b0, 1'b1, 1, 0, 8'h1C, 60};
    vecs[3] = '{8'h1C, 1'b1, 1'b1, PARITY_CHK ? 0 : 1, PARITY_CHK ? 1 : 0, 8'h1C, 60};
    vecs[4] = '{8'h5A, 1'b1, 1'b0, 0, 1, 8'h1C, 60};
    vecs[5] = '{8'h5A, 1'b1, 1'b1, 1, 0, 8'h5A, 60};

    waitCycles(5);
    check("reset valid", int'(valid), 0);
    check("reset frame_err", int'(frame_err), 0);
    check("reset scan_code", int'(scan_code), 0);
    rst_n = 1'b1;
    waitCycles(20);

    for (int i = 0; i < 6; i++) begin
      v0 = vCount;
      e0 = eCount;
      applyStimulus(vecs[i].data, vecs[i].par, vecs[i].stop, 11, -1, -1);
      waitCycles(vecs[i].gap);
      checkOutput($sformatf("vec%0d", i), v0, e0, vecs[i].expValid, vecs[i].expErr, vecs[i].expCode);
      if (vecs[i].expValid == 1)
        check($sformatf("vec%0d latency", i), lastValidCyc - lastFall, PULSE_LAT);
    end

    // Random frames judged at frame level: good stop bit and (optionally) odd parity.
    modelCode = 8'h5A;
    for (int i = 0; i < 30; i++) begin
      rData = 8'($urandom);
      rPar  = ~^rData;
      if ($urandom_range(3) == 0) rPar = ~rPar;
      rStop = ($urandom_range(4) != 0);
      rOk   = rStop && (!PARITY_CHK || (^{rData, rPar}) == 1'b1);
      if (rOk) modelCode = rData;
      v0 = vCount;
      e0 = eCount;
      applyStimulus(rData, rPar, rStop, 11, -1, -1);
      waitCycles($urandom_range(60));
      checkOutput($sformatf("rand%0d", i), v0, e0, rOk ? 1 : 0, rOk ? 0 : 1, modelCode);
    end

    // Clocking stops after four data bits; the watchdog must discard the byte.
    v0 = vCount;
    e0 = eCount;
    applyStimulus(8'hA7, 1'b1, 1'b1, 5, -1, -1);
    waitCycles(TIMEOUT_CYC + 60);
    checkOutput("timeout", v0, e0, 0, 1, modelCode);
    check("timeout latency", lastErrCyc - lastFall, PULSE_LAT + TIMEOUT_CYC);
    v0 = vCount;
    e0 = eCount;
    applyStimulus(8'h29, 1'b0, 1'b1, 11, -1, -1);
    waitCycles(60);
    checkOutput("after timeout", v0, e0, 1, 0, 8'h29);

    // Seven-cycle clock glitches, idle and mid-frame, must be filtered out.
    v0 = vCount;
    e0 = eCount;
    ps2_clk = 1'b0;
    waitCycles(7);
    ps2_clk = 1'b1;
    waitCycles(20);
    applyStimulus(8'h1C, 1'b0, 1'b1, 11, 3, -1);
    waitCycles(60);
    checkOutput("glitch", v0, e0, 1, 0, 8'h1C);

    // Reset during bit 5 aborts the frame with no pulse.
    v0 = vCount;
    e0 = eCount;
    applyStimulus(8'h33, 1'b1, 1'b1, 11, -1, 5);
    check("midreset valid", int'(valid), 0);
    check("midreset frame_err", int'(frame_err), 0);
    checkOutput("midreset", v0, e0, 0, 0, 8'h00);
    rst_n = 1'b1;
    waitCycles(40);
    checkOutput("after reset idle", v0, e0, 0, 0, 8'h00);
    v0 = vCount;
    e0 = eCount;
    applyStimulus(8'h1C, 1'b0, 1'b1, 11, -1, -1);
    waitCycles(60);
    checkOutput("after reset frame", v0, e0, 1, 0, 8'h1C);

    check("valid/frame_err overlap", overlapCount, 0);
    check("stretched pulses", longCount, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
